smart_flit_rx_buffer: RTL and testbench

- Receive end of the credit-based SMART link.
- Accepts FlitFixedData flits (33 b: bit 32 = parity, bits 31:0 = payload) from an upstream router output port.
- Buffers them in a DEPTH-entry FIFO and presents them to the local consumer (PE/ALU_T/TREG mux) through a valid/ready interface.
- Returns one Credit pulse upstream per flit dequeued, so the upstream credit counter, initialised to DEPTH at reset, never overruns the buffer.

---
 rtl/smart_flit_rx_buffer.sv | 105 ++++++++++
 tb/tb_smart_flit_rx_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/smart_flit_rx_buffer.sv
// smart_flit_rx_buffer: receive end of the credit-based SMART link.
// Buffers incoming flits in a DEPTH-entry FIFO, presents the head flit on a
// valid/ready interface and returns one credit pulse upstream per dequeue.
// Optional feature macro: RX_BYPASS_EN (same-cycle bypass when empty).
module smart_flit_rx_buffer #(
   parameter int DEPTH      = 4,
   parameter int FLIT_WIDTH = 33
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flit_in_valid,
   input  logic [FLIT_WIDTH-1:0]        flit_in,
   output logic                         credit_out,
   output logic                         flit_out_valid,
   output logic [FLIT_WIDTH-1:0]        flit_out,
   input  logic                         flit_out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic                         parity_err,
   output logic                         overflow_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH+1);

   logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
   logic [FLIT_WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [OW-1:0]         occ_q, occ_d;
   logic                  credit_q, credit_d;
   logic                  parity_err_q, parity_err_d;
   logic                  overflow_q, overflow_d;

   logic                  empty, full;
   logic                  fifo_deq;   // head of the FIFO leaves
   logic                  deq;        // any flit handed to the consumer
   logic                  enq;        // flit written into storage
   logic                  byp_take;   // flit consumed straight from flit_in

   // Output view of the head flit, with optional bypass when the buffer is empty
   always_comb begin
      empty          = (occ_q == '0);
      full           = (occ_q == OW'(DEPTH));
      flit_out       = mem_q[rd_ptr_q];
      flit_out_valid = !empty;
      byp_take       = 1'b0;
`ifdef RX_BYPASS_EN
      if (empty && flit_in_valid) begin
         flit_out       = flit_in;
         flit_out_valid = 1'b1;
         byp_take       = flit_out_ready;
      end
`endif
      fifo_deq = !empty && flit_out_ready;
      deq      = fifo_deq || byp_take;
      // A full buffer still accepts a flit when its head leaves this cycle
      enq      = flit_in_valid && (!full || fifo_deq) && !byp_take;
   end

   // Next-state for storage, pointers, occupancy and the registered pulses
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (enq) begin
         mem_d[wr_ptr_q] = flit_in;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (fifo_deq) rd_ptr_d = rd_ptr_q + PW'(1);
      if (enq && !fifo_deq)      occ_d = occ_q + OW'(1);
      else if (!enq && fifo_deq) occ_d = occ_q - OW'(1);
      credit_d     = deq;
      // Even parity: the MSB must equal the XOR of the payload bits
      parity_err_d = deq && (flit_out[FLIT_WIDTH-1] != ^flit_out[FLIT_WIDTH-2:0]);
      overflow_d   = overflow_q || (flit_in_valid && full && !fifo_deq);
   end

   // State registers; reset discards all buffered flits at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         occ_q        <= '0;
         credit_q     <= 1'b0;
         parity_err_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
         credit_q     <= credit_d;
         parity_err_q <= parity_err_d;
         overflow_q   <= overflow_d;
      end
   end

   assign credit_out   = credit_q;
   assign parity_err   = parity_err_q;
   assign overflow_err = overflow_q;
   assign occupancy    = occ_q;

endmodule

// File: tb/tb_smart_flit_rx_buffer.sv
// Directed self-checking bench for smart_flit_rx_buffer (default build, DEPTH=4).
module tb_smart_flit_rx_buffer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flit_in_valid = 1'b0;
   logic [32:0] flit_in = '0;
   logic        credit_out;
   logic        flit_out_valid;
   logic [32:0] flit_out;
   logic        flit_out_ready = 1'b0;
   logic [2:0]  occupancy;
   logic        parity_err;
   logic        overflow_err;

   int checks = 0;
   int errors = 0;
   int credits;
   int idx;

   smart_flit_rx_buffer #(.DEPTH(4), .FLIT_WIDTH(33)) dut (
      .clk            (clk),
      .reset          (reset),
      .flit_in_valid  (flit_in_valid),
      .flit_in        (flit_in),
      .credit_out     (credit_out),
      .flit_out_valid (flit_out_valid),
      .flit_out       (flit_out),
      .flit_out_ready (flit_out_ready),
      .occupancy      (occupancy),
      .parity_err     (parity_err),
      .overflow_err   (overflow_err)
   );

   always #5 clk = ~clk;

   // Flit with correct even parity
   function automatic logic [32:0] mk(input logic [31:0] p);
      return {^p, p};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      #3;
      chk("rst_valid", 64'(flit_out_valid), 0);
      chk("rst_occ",   64'(occupancy), 0);
      chk("rst_credit",64'(credit_out), 0);
      chk("rst_perr",  64'(parity_err), 0);
      chk("rst_ovf",   64'(overflow_err), 0);
      @(negedge clk);
      reset = 1'b0;
      step();

      // Single bad-parity flit, ready held high
      flit_in_valid = 1'b1; flit_in = 33'h0_0000_0001; flit_out_ready = 1'b1;
      step();
      flit_in_valid = 1'b0;
      chk("s_valid", 64'(flit_out_valid), 1);
      chk("s_data",  64'(flit_out), 64'h1);
      chk("s_occ1",  64'(occupancy), 1);
      chk("s_cr0",   64'(credit_out), 0);
      step();
      chk("s_cr1",   64'(credit_out), 1);
      chk("s_perr1", 64'(parity_err), 1);
      chk("s_occ0",  64'(occupancy), 0);
      chk("s_vld0",  64'(flit_out_valid), 0);
      step();
      chk("s_cr_end",   64'(credit_out), 0);
      chk("s_perr_end", 64'(parity_err), 0);

      // Fill to DEPTH with ready low, then drain
      flit_out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         flit_in_valid = 1'b1; flit_in = mk(32'(i)); step();
      end
      flit_in_valid = 1'b0;
      chk("f_occ",  64'(occupancy), 4);
      chk("f_head", 64'(flit_out), 64'(mk(1)));
      chk("f_cr",   64'(credit_out), 0);
      chk("f_ovf",  64'(overflow_err), 0);
      flit_out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("f_order", 64'(flit_out), 64'(mk(32'(i))));
         step();
         chk("f_credit", 64'(credit_out), 1);
         chk("f_perr",   64'(parity_err), 0);
      end
      chk("f_empty", 64'(occupancy), 0);
      chk("f_vld0",  64'(flit_out_valid), 0);
      flit_out_ready = 1'b0;
      step();
      chk("f_cr_end", 64'(credit_out), 0);

      // Full plus simultaneous enqueue/dequeue
      for (int i = 1; i <= 4; i++) begin
         flit_in_valid = 1'b1; flit_in = mk(32'(i)); step();
      end
      flit_in = mk(5); flit_out_ready = 1'b1;
      chk("sim_head", 64'(flit_out), 64'(mk(1)));
      step();
      flit_in_valid = 1'b0;
      chk("sim_occ", 64'(occupancy), 4);
      chk("sim_ovf", 64'(overflow_err), 0);
      chk("sim_cr",  64'(credit_out), 1);
      for (int i = 2; i <= 5; i++) begin
         chk("sim_order", 64'(flit_out), 64'(mk(32'(i))));
         step();
      end
      chk("sim_empty", 64'(occupancy), 0);
      flit_out_ready = 1'b0;
      step();

      // Overflow: full, no dequeue, extra flit dropped
      for (int i = 1; i <= 4; i++) begin
         flit_in_valid = 1'b1; flit_in = mk(32'(i)); step();
      end
      flit_in = mk(6);
      step();
      flit_in_valid = 1'b0;
      chk("ov_flag", 64'(overflow_err), 1);
      chk("ov_occ",  64'(occupancy), 4);
      chk("ov_head", 64'(flit_out), 64'(mk(1)));
      flit_out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("ov_order", 64'(flit_out), 64'(mk(32'(i))));
         step();
         chk("ov_sticky", 64'(overflow_err), 1);
      end
      chk("ov_empty", 64'(occupancy), 0);
      chk("ov_vld0",  64'(flit_out_valid), 0);
      flit_out_ready = 1'b0;
      step();

      // Wrap: 10 flits streamed with ready held high
      flit_out_ready = 1'b1;
      credits = 0;
      idx = 0;
      for (int s = 0; s < 14; s++) begin
         flit_in_valid = (s < 10);
         flit_in = mk(32'(10 + s));
         if (flit_out_valid) begin
            chk("w_order", 64'(flit_out), 64'(mk(32'(10 + idx))));
            idx++;
         end
         step();
         if (credit_out) credits++;
         chk("w_occ_le1", 64'(occupancy <= 3'd1), 1);
      end
      chk("w_delivered", 64'(idx), 10);
      chk("w_credits",   64'(credits), 10);
      flit_in_valid = 1'b0;
      flit_out_ready = 1'b0;
      step();

      // Reset mid-stream with three flits buffered
      for (int i = 1; i <= 3; i++) begin
         flit_in_valid = 1'b1; flit_in = mk(32'(20 + i)); step();
      end
      flit_in_valid = 1'b0;
      chk("r_occ3", 64'(occupancy), 3);
      #2 reset = 1'b1;
      #1;
      chk("r_occ",   64'(occupancy), 0);
      chk("r_valid", 64'(flit_out_valid), 0);
      chk("r_cr",    64'(credit_out), 0);
      chk("r_perr",  64'(parity_err), 0);
      chk("r_ovf",   64'(overflow_err), 0);
      #3 reset = 1'b0;
      flit_in_valid = 1'b1; flit_in = mk(32'h7);
      step();
      flit_in_valid = 1'b0;
      chk("r_new_vld",  64'(flit_out_valid), 1);
      chk("r_new_data", 64'(flit_out), 64'(mk(32'h7)));
      flit_out_ready = 1'b1;
      step();
      chk("r_new_cr",   64'(credit_out), 1);
      chk("r_new_occ",  64'(occupancy), 0);
      step();
      chk("r_cr_end",   64'(credit_out), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
